mgmt_phy_target_frm_monitor: RTL and testbench



---
 rtl/ltpi_pkg.sv | 71 +++++++
 rtl/mgmt_phy_frm_lock_cnt.sv | 52 +++++
 rtl/mgmt_phy_target_frm_monitor.sv | 230 +++++++++++++++++++++++
 tb/tb_mgmt_phy_target_frm_monitor.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ltpi_pkg.sv
// ----------------------------------------------------------------------------
// ltpi_pkg
//   Shared LTPI types and defaults for the Target PHY management path.
//   - rstate_t        : Target link state, fed back from the link state machine
//   - ltpi_frm_type_t : decoded receive frame type from the deframer
//   - *_DEF constants : default lock / loss / timeout thresholds
//   - st_monitored()  : states in which the frame monitor is active
//   - frm_allowed()   : frame types that are legal in a given state
// ----------------------------------------------------------------------------
package ltpi_pkg;

    typedef enum logic [3:0] {
        ST_INIT                       = 4'd0,
        ST_WAIT_LINK_DETECT_LOCKED    = 4'd1,
        ST_WAIT_LINK_SPEED_LOCKED     = 4'd2,
        ST_LINK_SPEED_CHANGE          = 4'd3,
        ST_WAIT_LINK_ADVERTISE_LOCKED = 4'd4,
        ST_WAIT_IN_ADVERTISE          = 4'd5,
        ST_CONFIGURATION_OR_ACCEPT    = 4'd6,
        ST_OPERATIONAL                = 4'd7,
        ST_LINK_LOST_ERR              = 4'd8
    } rstate_t;

    typedef enum logic [2:0] {
        FRM_DETECT    = 3'd0,
        FRM_SPEED     = 3'd1,
        FRM_ADVERTISE = 3'd2,
        FRM_CONFIGURE = 3'd3,
        FRM_ACCEPT    = 3'd4,
        FRM_DEFAULT   = 3'd5
    } ltpi_frm_type_t;

    localparam int DETECT_LOCK_CNT_DEF  = 7;
    localparam int SPEED_LOCK_CNT_DEF   = 7;
    localparam int ADV_LOCK_CNT_DEF     = 7;
    localparam int CRC_LOSS_CNT_DEF     = 3;
    localparam int TX_DETECT_CNT_DEF    = 255;
    localparam int SPEED_TIMEOUT_DEF    = 6_000_000;
    localparam int ACCEPT_TIMEOUT_60MHZ = 60_000;

    function automatic logic st_monitored(input rstate_t st);
        case (st)
            ST_WAIT_LINK_DETECT_LOCKED,
            ST_WAIT_LINK_SPEED_LOCKED,
            ST_WAIT_LINK_ADVERTISE_LOCKED,
            ST_WAIT_IN_ADVERTISE,
            ST_CONFIGURATION_OR_ACCEPT,
            ST_OPERATIONAL:               st_monitored = 1'b1;
            default:                      st_monitored = 1'b0;
        endcase
    endfunction

    function automatic logic frm_allowed(input rstate_t st, input ltpi_frm_type_t t);
        case (st)
            ST_WAIT_LINK_DETECT_LOCKED,
            ST_WAIT_LINK_SPEED_LOCKED:
                frm_allowed = (t == FRM_DETECT) || (t == FRM_SPEED);
            ST_WAIT_LINK_ADVERTISE_LOCKED,
            ST_WAIT_IN_ADVERTISE:
                frm_allowed = (t == FRM_ADVERTISE) || (t == FRM_CONFIGURE);
            ST_CONFIGURATION_OR_ACCEPT:
                frm_allowed = (t == FRM_CONFIGURE) || (t == FRM_ACCEPT) ||
                              (t == FRM_ADVERTISE);
            ST_OPERATIONAL:
                frm_allowed = (t == FRM_DEFAULT);
            default:
                frm_allowed = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mgmt_phy_frm_lock_cnt.sv
// ----------------------------------------------------------------------------
// mgmt_phy_frm_lock_cnt
//   Consecutive-event saturating 8-bit counter with a sticky threshold flag.
//   The flag registers on the same edge the counter reaches THRESH, so it is
//   visible the cycle after the event that completed the run.
// Ports:
//   clk    in   system clock
//   reset  in   synchronous, active-high
//   clear  in   phase change: clears count and flag
//   inc    in   matching event, count up (saturates at 0xFF)
//   zero   in   breaking event, count back to 0 (flag is kept)
//   hit    out  sticky: count has reached THRESH since the last clear
// ----------------------------------------------------------------------------
module mgmt_phy_frm_lock_cnt #(
    parameter int THRESH = 7
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    input  logic zero,
    output logic hit
);

    localparam logic [7:0] TH = 8'(THRESH);

    logic [7:0] cnt;
    logic [7:0] cnt_nxt_p0;

    always_comb begin
        cnt_nxt_p0 = cnt;
        if (zero) begin
            cnt_nxt_p0 = 8'd0;
        end else if (inc && (cnt != 8'hFF)) begin
            cnt_nxt_p0 = cnt + 8'd1;
        end
    end

    // stage p0 -> p1: count and threshold flag
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= 8'd0;
            hit <= 1'b0;
        end else begin
            cnt <= cnt_nxt_p0;
            if (cnt_nxt_p0 >= TH) begin
                hit <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/mgmt_phy_target_frm_monitor.sv
// ----------------------------------------------------------------------------
// mgmt_phy_target_frm_monitor
//   Receive-side frame monitor for the LTPI Target PHY management path. It
//   turns per-frame decode results (type + CRC status) and TX completion
//   pulses into the lock / receive / loss / error / timeout qualifiers used
//   by the Target link state machine. Behaviour depends on LTPI_link_ST.
//   Any change of LTPI_link_ST clears every counter and sticky output in that
//   cycle, and a frame arriving in that cycle is discarded.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   LTPI_link_ST                current Target link state (rstate_t)
//   rx_frm_valid                one-cycle pulse per received frame
//   rx_frm_type                 decoded frame type
//   rx_frm_crc_err              CRC failure, qualified by rx_frm_valid
//   tx_frm_done                 TX side completed one frame
//   tx_frm_is_detect            that frame was a detect frame
//   link_detect_locked          sticky: DETECT_LOCK_CNT consecutive detects
//   link_speed_locked           sticky: SPEED_LOCK_CNT consecutive speeds
//   advertise_locked            sticky: ADV_LOCK_CNT consecutive advertises
//   configure_frm_recv          sticky: good configure frame seen
//   accept_frm_recv             sticky: good accept frame seen
//   transmited_255_detect_frm   sticky: TX_DETECT_CNT detect frames sent
//   crc_consec_loss             sticky: CRC_LOSS_CNT consecutive CRC errors
//   unexpected_frame_error      pulse: good frame not allowed in this state
//   link_speed_timeout_detect   sticky: speed-lock wait expired
//   link_accept_timeout_detect  sticky: no accept frame in time
//
// Optional build macro MGMT_PHY_FRM_MON_STATS_EN adds crc_err_total and
// unexpected_total, 16-bit saturating counters cleared only by reset.
// ----------------------------------------------------------------------------
module mgmt_phy_target_frm_monitor
    import ltpi_pkg::*;
#(
    parameter int DETECT_LOCK_CNT    = DETECT_LOCK_CNT_DEF,
    parameter int SPEED_LOCK_CNT     = SPEED_LOCK_CNT_DEF,
    parameter int ADV_LOCK_CNT       = ADV_LOCK_CNT_DEF,
    parameter int CRC_LOSS_CNT       = CRC_LOSS_CNT_DEF,
    parameter int TX_DETECT_CNT      = TX_DETECT_CNT_DEF,
    parameter int SPEED_TIMEOUT_CLK  = SPEED_TIMEOUT_DEF,
    parameter int ACCEPT_TIMEOUT_CLK = ACCEPT_TIMEOUT_60MHZ
) (
    input  logic           clk,
    input  logic           reset,
    input  rstate_t        LTPI_link_ST,
    input  logic           rx_frm_valid,
    input  ltpi_frm_type_t rx_frm_type,
    input  logic           rx_frm_crc_err,
    input  logic           tx_frm_done,
    input  logic           tx_frm_is_detect,
    output logic           link_detect_locked,
    output logic           link_speed_locked,
    output logic           advertise_locked,
    output logic           configure_frm_recv,
    output logic           accept_frm_recv,
    output logic           transmited_255_detect_frm,
    output logic           crc_consec_loss,
    output logic           unexpected_frame_error,
    output logic           link_speed_timeout_detect,
`ifdef MGMT_PHY_FRM_MON_STATS_EN
    output logic [15:0]    crc_err_total,
    output logic [15:0]    unexpected_total,
`endif
    output logic           link_accept_timeout_detect
);

    localparam logic [31:0] SPD_LIM = 32'(SPEED_TIMEOUT_CLK - 1);
    localparam logic [31:0] ACC_LIM = 32'(ACCEPT_TIMEOUT_CLK - 1);

    rstate_t     st_prev;
    logic [31:0] spd_tmr;
    logic [31:0] acc_tmr;

    logic st_chg_p0;
    logic fv_p0;
    logic good_p0;
    logic bad_p0;
    logic allowed_p0;
    logic det_inc_p0;
    logic spd_inc_p0;
    logic adv_inc_p0;
    logic tx_inc_p0;
    logic cfg_ok_p0;
    logic acc_ok_p0;
    logic unexp_p0;
    logic spd_run_p0;
    logic acc_run_p0;

    // Frame qualification: only frames in a monitored state that do not
    // coincide with a phase change are processed at all.
    always_comb begin
        st_chg_p0  = (LTPI_link_ST != st_prev);
        fv_p0      = rx_frm_valid && st_monitored(LTPI_link_ST) && !st_chg_p0;
        good_p0    = fv_p0 && !rx_frm_crc_err;
        bad_p0     = fv_p0 && rx_frm_crc_err;
        allowed_p0 = frm_allowed(LTPI_link_ST, rx_frm_type);

        det_inc_p0 = good_p0 && (rx_frm_type == FRM_DETECT) &&
                     (LTPI_link_ST == ST_WAIT_LINK_DETECT_LOCKED);
        spd_inc_p0 = good_p0 && (rx_frm_type == FRM_SPEED) &&
                     (LTPI_link_ST == ST_WAIT_LINK_SPEED_LOCKED);
        adv_inc_p0 = good_p0 && (rx_frm_type == FRM_ADVERTISE) &&
                     ((LTPI_link_ST == ST_WAIT_LINK_ADVERTISE_LOCKED) ||
                      (LTPI_link_ST == ST_WAIT_IN_ADVERTISE));
        tx_inc_p0  = tx_frm_done && tx_frm_is_detect && !st_chg_p0 &&
                     (LTPI_link_ST == ST_WAIT_LINK_DETECT_LOCKED);

        cfg_ok_p0  = good_p0 && allowed_p0 && (rx_frm_type == FRM_CONFIGURE);
        acc_ok_p0  = good_p0 && allowed_p0 && (rx_frm_type == FRM_ACCEPT);
        unexp_p0   = good_p0 && !allowed_p0;

        spd_run_p0 = !st_chg_p0 && (LTPI_link_ST == ST_WAIT_LINK_SPEED_LOCKED);
        acc_run_p0 = !st_chg_p0 && (LTPI_link_ST == ST_CONFIGURATION_OR_ACCEPT);
    end

    // Each lock run is broken by any other good frame or by a CRC error.
    mgmt_phy_frm_lock_cnt #(.THRESH(DETECT_LOCK_CNT)) u_det_lock (
        .clk   (clk),
        .reset (reset),
        .clear (st_chg_p0),
        .inc   (det_inc_p0),
        .zero  ((good_p0 && !det_inc_p0) || bad_p0),
        .hit   (link_detect_locked)
    );

    mgmt_phy_frm_lock_cnt #(.THRESH(SPEED_LOCK_CNT)) u_spd_lock (
        .clk   (clk),
        .reset (reset),
        .clear (st_chg_p0),
        .inc   (spd_inc_p0),
        .zero  ((good_p0 && !spd_inc_p0) || bad_p0),
        .hit   (link_speed_locked)
    );

    mgmt_phy_frm_lock_cnt #(.THRESH(ADV_LOCK_CNT)) u_adv_lock (
        .clk   (clk),
        .reset (reset),
        .clear (st_chg_p0),
        .inc   (adv_inc_p0),
        .zero  ((good_p0 && !adv_inc_p0) || bad_p0),
        .hit   (advertise_locked)
    );

    // CRC run: counts errored frames, any good frame restarts it.
    mgmt_phy_frm_lock_cnt #(.THRESH(CRC_LOSS_CNT)) u_crc_lock (
        .clk   (clk),
        .reset (reset),
        .clear (st_chg_p0),
        .inc   (bad_p0),
        .zero  (good_p0),
        .hit   (crc_consec_loss)
    );

    // TX detect frames are never "broken"; only a phase change restarts them.
    mgmt_phy_frm_lock_cnt #(.THRESH(TX_DETECT_CNT)) u_tx_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (st_chg_p0),
        .inc   (tx_inc_p0),
        .zero  (1'b0),
        .hit   (transmited_255_detect_frm)
    );

    // stage p0 -> p1: previous state for phase-change detection
    always_ff @(posedge clk) begin
        if (reset) begin
            st_prev <= ST_INIT;
        end else begin
            st_prev <= LTPI_link_ST;
        end
    end

    // stage p0 -> p1: receive flags, unexpected pulse, timeouts
    always_ff @(posedge clk) begin
        if (reset || st_chg_p0) begin
            configure_frm_recv         <= 1'b0;
            accept_frm_recv            <= 1'b0;
            unexpected_frame_error     <= 1'b0;
            spd_tmr                    <= 32'd0;
            acc_tmr                    <= 32'd0;
            link_speed_timeout_detect  <= 1'b0;
            link_accept_timeout_detect <= 1'b0;
        end else begin
            if (cfg_ok_p0) begin
                configure_frm_recv <= 1'b1;
            end
            if (acc_ok_p0) begin
                accept_frm_recv <= 1'b1;
            end
            unexpected_frame_error <= unexp_p0;

            // Timers hold at their limit once the timeout has been flagged.
            if (spd_run_p0) begin
                if (spd_tmr == SPD_LIM) begin
                    link_speed_timeout_detect <= 1'b1;
                end else begin
                    spd_tmr <= spd_tmr + 32'd1;
                end
            end

            if (acc_run_p0) begin
                if (acc_ok_p0) begin
                    acc_tmr <= 32'd0;
                end else if (acc_tmr == ACC_LIM) begin
                    link_accept_timeout_detect <= 1'b1;
                end else begin
                    acc_tmr <= acc_tmr + 32'd1;
                end
            end
        end
    end

`ifdef MGMT_PHY_FRM_MON_STATS_EN
    // stage p0 -> p1: lifetime statistics, survive phase changes
    always_ff @(posedge clk) begin
        if (reset) begin
            crc_err_total    <= 16'd0;
            unexpected_total <= 16'd0;
        end else begin
            if (bad_p0 && (crc_err_total != 16'hFFFF)) begin
                crc_err_total <= crc_err_total + 16'd1;
            end
            if (unexp_p0 && (unexpected_total != 16'hFFFF)) begin
                unexpected_total <= unexpected_total + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mgmt_phy_target_frm_monitor.sv
// ----------------------------------------------------------------------------
// tb_mgmt_phy_target_frm_monitor
//   Directed bench for mgmt_phy_target_frm_monitor. Inputs change on the
//   falling edge; outputs are sampled on the falling edge after each rising
//   edge. Timeouts are shortened (speed 40, accept 100 clocks).
// ----------------------------------------------------------------------------
module tb_mgmt_phy_target_frm_monitor;
    import ltpi_pkg::*;

    logic           clk;
    logic           reset;
    rstate_t        LTPI_link_ST;
    logic           rx_frm_valid;
    ltpi_frm_type_t rx_frm_type;
    logic           rx_frm_crc_err;
    logic           tx_frm_done;
    logic           tx_frm_is_detect;
    logic           link_detect_locked;
    logic           link_speed_locked;
    logic           advertise_locked;
    logic           configure_frm_recv;
    logic           accept_frm_recv;
    logic           transmited_255_detect_frm;
    logic           crc_consec_loss;
    logic           unexpected_frame_error;
    logic           link_speed_timeout_detect;
    logic           link_accept_timeout_detect;
`ifdef MGMT_PHY_FRM_MON_STATS_EN
    logic [15:0]    crc_err_total;
    logic [15:0]    unexpected_total;
`endif

    int passed;
    int total;

    mgmt_phy_target_frm_monitor #(
        .SPEED_TIMEOUT_CLK  (40),
        .ACCEPT_TIMEOUT_CLK (100)
    ) dut (
        .clk                        (clk),
        .reset                      (reset),
        .LTPI_link_ST               (LTPI_link_ST),
        .rx_frm_valid               (rx_frm_valid),
        .rx_frm_type                (rx_frm_type),
        .rx_frm_crc_err             (rx_frm_crc_err),
        .tx_frm_done                (tx_frm_done),
        .tx_frm_is_detect           (tx_frm_is_detect),
        .link_detect_locked         (link_detect_locked),
        .link_speed_locked          (link_speed_locked),
        .advertise_locked           (advertise_locked),
        .configure_frm_recv         (configure_frm_recv),
        .accept_frm_recv            (accept_frm_recv),
        .transmited_255_detect_frm  (transmited_255_detect_frm),
        .crc_consec_loss            (crc_consec_loss),
        .unexpected_frame_error     (unexpected_frame_error),
        .link_speed_timeout_detect  (link_speed_timeout_detect),
`ifdef MGMT_PHY_FRM_MON_STATS_EN
        .crc_err_total              (crc_err_total),
        .unexpected_total           (unexpected_total),
`endif
        .link_accept_timeout_detect (link_accept_timeout_detect)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_state(input rstate_t st);
        LTPI_link_ST = st;
        step();
    endtask

    task automatic send_frm(input ltpi_frm_type_t t, input logic crc);
        rx_frm_valid   = 1'b1;
        rx_frm_type    = t;
        rx_frm_crc_err = crc;
        step();
        rx_frm_valid   = 1'b0;
        rx_frm_crc_err = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        step();
        total++;
        if ({link_detect_locked, link_speed_locked, advertise_locked, configure_frm_recv,
             accept_frm_recv, transmited_255_detect_frm, crc_consec_loss,
             unexpected_frame_error, link_speed_timeout_detect,
             link_accept_timeout_detect} !== 10'b0)
            $display("FAIL reset_outputs: got %b expected all 0",
                     {link_detect_locked, link_speed_locked, advertise_locked,
                      configure_frm_recv, accept_frm_recv, transmited_255_detect_frm,
                      crc_consec_loss, unexpected_frame_error,
                      link_speed_timeout_detect, link_accept_timeout_detect});
        else passed++;
    endtask

    task automatic test_detect_lock();
        set_state(ST_WAIT_LINK_DETECT_LOCKED);
        for (int i = 0; i < 6; i++) send_frm(FRM_DETECT, 1'b0);
        total++;
        if (link_detect_locked !== 1'b0)
            $display("FAIL detect_6good: got %0b expected 0", link_detect_locked);
        else passed++;
        send_frm(FRM_DETECT, 1'b0);
        total++;
        if (link_detect_locked !== 1'b1)
            $display("FAIL detect_7good: got %0b expected 1", link_detect_locked);
        else passed++;

        // restart the phase, then break the run with a CRC error
        set_state(ST_WAIT_LINK_SPEED_LOCKED);
        set_state(ST_WAIT_LINK_DETECT_LOCKED);
        total++;
        if (link_detect_locked !== 1'b0)
            $display("FAIL detect_cleared_on_phase: got %0b expected 0", link_detect_locked);
        else passed++;
        for (int i = 0; i < 6; i++) send_frm(FRM_DETECT, 1'b0);
        send_frm(FRM_DETECT, 1'b1);
        for (int i = 0; i < 6; i++) send_frm(FRM_DETECT, 1'b0);
        total++;
        if (link_detect_locked !== 1'b0)
            $display("FAIL detect_after_crc_6: got %0b expected 0", link_detect_locked);
        else passed++;
        send_frm(FRM_DETECT, 1'b0);
        total++;
        if (link_detect_locked !== 1'b1)
            $display("FAIL detect_after_crc_7: got %0b expected 1", link_detect_locked);
        else passed++;
    endtask

    task automatic test_phase_discard();
        set_state(ST_INIT);
        // frame coincides with the phase change and must be dropped
        LTPI_link_ST = ST_WAIT_LINK_DETECT_LOCKED;
        send_frm(FRM_DETECT, 1'b0);
        for (int i = 0; i < 6; i++) send_frm(FRM_DETECT, 1'b0);
        total++;
        if (link_detect_locked !== 1'b0)
            $display("FAIL discard_on_chg: got %0b expected 0", link_detect_locked);
        else passed++;
        send_frm(FRM_DETECT, 1'b0);
        total++;
        if (link_detect_locked !== 1'b1)
            $display("FAIL discard_then_7: got %0b expected 1", link_detect_locked);
        else passed++;
    endtask

    task automatic test_speed();
        set_state(ST_WAIT_LINK_SPEED_LOCKED);
        for (int i = 0; i < 7; i++) send_frm(FRM_SPEED, 1'b0);
        total++;
        if (link_speed_locked !== 1'b1)
            $display("FAIL speed_lock: got %0b expected 1", link_speed_locked);
        else passed++;
        idle(32);   // 39 clocks in state
        total++;
        if (link_speed_timeout_detect !== 1'b0)
            $display("FAIL speed_timeout_early: got %0b expected 0", link_speed_timeout_detect);
        else passed++;
        step();     // 40 clocks in state
        total++;
        if (link_speed_timeout_detect !== 1'b1)
            $display("FAIL speed_timeout: got %0b expected 1", link_speed_timeout_detect);
        else passed++;
    endtask

    task automatic test_crc_loss();
        set_state(ST_WAIT_LINK_ADVERTISE_LOCKED);
        send_frm(FRM_ADVERTISE, 1'b1);
        send_frm(FRM_ADVERTISE, 1'b1);
        total++;
        if (crc_consec_loss !== 1'b0)
            $display("FAIL crc_loss_2: got %0b expected 0", crc_consec_loss);
        else passed++;
        send_frm(FRM_ADVERTISE, 1'b1);
        total++;
        if (crc_consec_loss !== 1'b1)
            $display("FAIL crc_loss_3: got %0b expected 1", crc_consec_loss);
        else passed++;
        set_state(ST_LINK_LOST_ERR);
        total++;
        if (crc_consec_loss !== 1'b0)
            $display("FAIL crc_loss_clear: got %0b expected 0", crc_consec_loss);
        else passed++;
        // unmonitored state: frames ignored entirely
        for (int i = 0; i < 3; i++) send_frm(FRM_DETECT, 1'b1);
        send_frm(FRM_ADVERTISE, 1'b0);
        total++;
        if ({crc_consec_loss, unexpected_frame_error} !== 2'b00)
            $display("FAIL idle_state_ignored: got %b expected 00",
                     {crc_consec_loss, unexpected_frame_error});
        else passed++;
    endtask

    task automatic test_unexpected();
        set_state(ST_OPERATIONAL);
        send_frm(FRM_ADVERTISE, 1'b0);
        total++;
        if (unexpected_frame_error !== 1'b1)
            $display("FAIL unexp_pulse: got %0b expected 1", unexpected_frame_error);
        else passed++;
        step();
        total++;
        if (unexpected_frame_error !== 1'b0)
            $display("FAIL unexp_one_cycle: got %0b expected 0", unexpected_frame_error);
        else passed++;
        send_frm(FRM_ADVERTISE, 1'b1);
        total++;
        if (unexpected_frame_error !== 1'b0)
            $display("FAIL unexp_crc_no_pulse: got %0b expected 0", unexpected_frame_error);
        else passed++;
        total++;
        if (dut.u_crc_lock.cnt !== 8'd1)
            $display("FAIL crc_cnt_one: got %0d expected 1", dut.u_crc_lock.cnt);
        else passed++;
        send_frm(FRM_DEFAULT, 1'b0);
        total++;
        if ({unexpected_frame_error, dut.u_crc_lock.cnt} !== 9'd0)
            $display("FAIL default_ok: got unexp=%0b crc_cnt=%0d expected 0/0",
                     unexpected_frame_error, dut.u_crc_lock.cnt);
        else passed++;
    endtask

    task automatic test_tx_detect();
        set_state(ST_WAIT_LINK_DETECT_LOCKED);
        tx_frm_done = 1'b1;
        tx_frm_is_detect = 1'b1;
        idle(254);
        tx_frm_done = 1'b0;
        total++;
        if (transmited_255_detect_frm !== 1'b0)
            $display("FAIL tx_254: got %0b expected 0", transmited_255_detect_frm);
        else passed++;
        tx_frm_done = 1'b1;
        step();
        tx_frm_done = 1'b0;
        total++;
        if (transmited_255_detect_frm !== 1'b1)
            $display("FAIL tx_255: got %0b expected 1", transmited_255_detect_frm);
        else passed++;

        set_state(ST_INIT);
        set_state(ST_WAIT_LINK_DETECT_LOCKED);
        tx_frm_done = 1'b1;
        idle(254);
        tx_frm_done = 1'b0;
        set_state(ST_WAIT_LINK_SPEED_LOCKED);
        total++;
        if (transmited_255_detect_frm !== 1'b0)
            $display("FAIL tx_254_then_chg: got %0b expected 0", transmited_255_detect_frm);
        else passed++;
        tx_frm_is_detect = 1'b0;
    endtask

    task automatic test_accept_timeout();
        set_state(ST_CONFIGURATION_OR_ACCEPT);
        idle(99);
        total++;
        if (link_accept_timeout_detect !== 1'b0)
            $display("FAIL acc_timeout_99: got %0b expected 0", link_accept_timeout_detect);
        else passed++;
        step();
        total++;
        if (link_accept_timeout_detect !== 1'b1)
            $display("FAIL acc_timeout_100: got %0b expected 1", link_accept_timeout_detect);
        else passed++;

        set_state(ST_OPERATIONAL);
        set_state(ST_CONFIGURATION_OR_ACCEPT);
        idle(49);
        send_frm(FRM_ACCEPT, 1'b0);   // cycle 50
        total++;
        if (accept_frm_recv !== 1'b1)
            $display("FAIL accept_recv: got %0b expected 1", accept_frm_recv);
        else passed++;
        idle(99);                     // cycle 149
        total++;
        if (link_accept_timeout_detect !== 1'b0)
            $display("FAIL acc_timeout_149: got %0b expected 0", link_accept_timeout_detect);
        else passed++;
        step();                       // cycle 150
        total++;
        if (link_accept_timeout_detect !== 1'b1)
            $display("FAIL acc_timeout_150: got %0b expected 1", link_accept_timeout_detect);
        else passed++;
        send_frm(FRM_CONFIGURE, 1'b0);
        send_frm(FRM_ADVERTISE, 1'b0);
        total++;
        if ({configure_frm_recv, unexpected_frame_error} !== 2'b10)
            $display("FAIL cfg_recv_adv_ok: got %b expected 10",
                     {configure_frm_recv, unexpected_frame_error});
        else passed++;
    endtask

`ifdef MGMT_PHY_FRM_MON_STATS_EN
    task automatic test_stats();
        set_state(ST_WAIT_LINK_ADVERTISE_LOCKED);
        rx_frm_valid   = 1'b1;
        rx_frm_type    = FRM_ADVERTISE;
        rx_frm_crc_err = 1'b1;
        idle(70000);
        rx_frm_valid   = 1'b0;
        rx_frm_crc_err = 1'b0;
        total++;
        if (crc_err_total !== 16'hFFFF)
            $display("FAIL stats_sat: got %h expected ffff", crc_err_total);
        else passed++;
        set_state(ST_OPERATIONAL);
        total++;
        if (crc_err_total !== 16'hFFFF)
            $display("FAIL stats_phase: got %h expected ffff", crc_err_total);
        else passed++;
        reset = 1'b1;
        step();
        reset = 1'b0;
        total++;
        if (crc_err_total !== 16'h0000)
            $display("FAIL stats_reset: got %h expected 0000", crc_err_total);
        else passed++;
    endtask
`endif

    initial begin
        passed           = 0;
        total            = 0;
        reset            = 1'b1;
        LTPI_link_ST     = ST_INIT;
        rx_frm_valid     = 1'b0;
        rx_frm_type      = FRM_DEFAULT;
        rx_frm_crc_err   = 1'b0;
        tx_frm_done      = 1'b0;
        tx_frm_is_detect = 1'b0;
        @(negedge clk);

        test_reset();
        test_detect_lock();
        test_phase_discard();
        test_speed();
        test_crc_loss();
        test_unexpected();
        test_tx_detect();
        test_accept_timeout();
`ifdef MGMT_PHY_FRM_MON_STATS_EN
        test_stats();
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
